alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter N, default 32, datapath width in bits; legal values are powers of two from 8 to 64.
REQ-002 Parameter SHW, default $clog2(N), shift-amount width, derived and not overridden.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous and active-low.
REQ-005 in_valid  in  1  operand/opcode presented.
REQ-006 in_ready  out  1  block can accept an operation.
REQ-007 a, b  in  N each  operands.
REQ-008 op  in  4  operation code.
REQ-009 out_valid  out  1  result presented.
REQ-010 out_ready  in  1  consumer accepts the result.
REQ-011 result  out  N  registered result.
REQ-012 zero  out  1  registered flag, high when result equals 0.
REQ-013 busy  out  1  high while a multi-cycle operation is iterating.

Function
REQ-014 Operation transfer occurs on a clock edge with in_valid and in_ready both high; a, b and op are captured at that edge.
REQ-015 Opcodes: 0000 add, 0001 sub, 0010 xor, 0011 or, 0100 and, 0101 sll, 0110 srl, 0111 slt (signed), 1000 sra, 1001 sltu, 1010 mul (low N bits), 1011 mulhu (high N bits, unsigned), 1100 divu, 1101 remu; 1110 and 1111 return a unchanged.
REQ-016 Add, sub and mul wrap modulo 2^N; no carry or overflow outputs.
REQ-017 Shifts use only b[SHW-1:0]; upper bits of b are ignored.
REQ-018 slt and sltu return 1 or 0, zero-extended to N bits.
REQ-019 zero is driven as (result == 0) for every opcode, including sub with a equal to b.
REQ-020 States: IDLE, ITER, DONE; in_ready is high only in IDLE.
REQ-021 IDLE to DONE on transfer of a single-cycle op (opcodes other than 1010 to 1101); result is valid on the next cycle, so latency is 1.
REQ-022 IDLE to ITER on transfer of mul, mulhu, divu or remu; ITER performs one shift-add or restoring-subtract step per cycle for exactly N cycles, then enters DONE; latency is N+1 cycles.
REQ-023 DONE holds out_valid high, with result and zero stable, until out_ready is high; it then returns to IDLE on that edge.
REQ-024 No new operation is accepted in the cycle the result is consumed; the minimum issue interval is 2 cycles.
REQ-025 divu by zero returns all ones; remu by zero returns a; both take the full N+1 cycles.
REQ-026 in_valid while in ITER or DONE has no effect; a and b changes after acceptance do not alter the pending result.
REQ-027 busy equals (state == ITER).

Reset
REQ-028 When rst_n is low at a clock edge: state goes to IDLE; out_valid, busy, result and zero go to 0; iteration counter and internal accumulators are cleared.
REQ-029 Reset asserted during ITER or DONE discards the in-flight operation without producing a result.
REQ-030 in_ready is 1 in the first cycle after rst_n is released.

Structure
REQ-031 A shared package alu_seq_pkg holds the op enum, the state enum and the constant set of multi-cycle opcodes.
REQ-032 The iterative multiply/divide datapath is one sub-module, alu_seq_muldiv (start, done, N-cycle counter); single-cycle ops stay in alu_seq.

Verification (N=32)
REQ-033 add a=0xFFFFFFFF, b=1 -> result 0, zero 1, out_valid 1 cycle after transfer.
REQ-034 sub a=5, b=5 -> result 0, zero 1; slt a=0xFFFFFFFF, b=1 -> 1; sltu with the same operands -> 0.
REQ-035 sra a=0x80000000, b=0x24 -> shift by 4 -> 0xF8000000; srl with the same operands -> 0x08000000.
REQ-036 mulhu a=b=0xFFFFFFFF -> 0xFFFFFFFE, out_valid exactly 33 cycles after transfer, busy high for 32 cycles.
REQ-037 divu a=7, b=0 -> 0xFFFFFFFF; remu a=7, b=0 -> 7; with out_ready held low for 5 cycles, result stays stable and in_ready stays low.
REQ-038 rst_n pulsed low in ITER cycle 10 of divu -> IDLE next cycle, out_valid never asserted, the next add completes correctly.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared definitions for the sequential ALU:
//   op_e        - 4-bit operation codes
//   state_e     - control FSM states (also exported on the debug port)
//   MULTI_OPS   - opcodes executed by the iterative multiply/divide unit
//   is_multi_op - membership test against MULTI_OPS
package alu_seq_pkg;

   typedef enum logic [3:0] {
      OP_ADD    = 4'h0,
      OP_SUB    = 4'h1,
      OP_XOR    = 4'h2,
      OP_OR     = 4'h3,
      OP_AND    = 4'h4,
      OP_SLL    = 4'h5,
      OP_SRL    = 4'h6,
      OP_SLT    = 4'h7,
      OP_SRA    = 4'h8,
      OP_SLTU   = 4'h9,
      OP_MUL    = 4'hA,
      OP_MULHU  = 4'hB,
      OP_DIVU   = 4'hC,
      OP_REMU   = 4'hD,
      OP_PASS_E = 4'hE,
      OP_PASS_F = 4'hF
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int NUM_MULTI = 4;
   localparam logic [3:0] MULTI_OPS [NUM_MULTI] = '{4'hA, 4'hB, 4'hC, 4'hD};

   function automatic logic is_multi_op(input op_e op);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < NUM_MULTI; i++) begin
         if (op == MULTI_OPS[i]) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if
// Operation/result handshake bundle of the sequential ALU.
//   in_valid/in_ready  : an operation (a, b, op) transfers on a rising edge
//                        where both are high; the source holds a, b, op and
//                        in_valid until that edge.
//   out_valid/out_ready: the result (result, zero) transfers on a rising edge
//                        where both are high; the ALU holds result, zero and
//                        out_valid stable until that edge.
//   busy               : high while a multi-cycle operation iterates.
// modport slave  - the ALU side
// modport master - the requester/consumer side
interface alu_seq_if #(parameter int N = 32);

   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [3:0]   op;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] result;
   logic         zero;
   logic         busy;

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, zero, busy
   );

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, zero, busy
   );

endinterface

// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv
// Iterative unsigned multiply (shift-add) and divide (restoring), one step
// per clock for exactly N clocks after start_i.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   start_i     - load operands and begin iterating (only issued while idle)
//   op_i        - OP_MUL, OP_MULHU, OP_DIVU or OP_REMU
//   a_i, b_i    - operands, sampled with start_i
//   done_o      - high in the cycle whose rising edge performs the last step
//   res_o       - result of that last step, valid while done_o is high
module alu_seq_muldiv
   import alu_seq_pkg::*;
#(
   parameter int N   = 32,
   parameter int SHW = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start_i,
   input  op_e          op_i,
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   output logic         done_o,
   output logic [N-1:0] res_o
);

   // hi/lo hold {upper product, lower product/multiplier} when multiplying
   // and {remainder, quotient/dividend} when dividing.
   logic [N-1:0]   hi_q, hi_d;
   logic [N-1:0]   lo_q, lo_d;
   logic [N-1:0]   opnd_q;
   op_e            op_q;
   logic           active_q;
   logic [SHW-1:0] cnt_q;

   logic           is_div;
   logic [N:0]     mul_sum;
   logic [N:0]     div_shift;
   logic [N:0]     div_trial;

   assign is_div = (op_q == OP_DIVU) || (op_q == OP_REMU);

   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      div_shift = {hi_q, lo_q[N-1]};
      div_trial = div_shift - {1'b0, opnd_q};
      hi_d      = hi_q;
      lo_d      = lo_q;
      if (is_div) begin
         // Restoring step: keep the trial difference only if it did not borrow.
         // A zero divisor never borrows, giving an all-ones quotient and a
         // remainder that collects the dividend unchanged.
         if (!div_trial[N]) begin
            hi_d = div_trial[N-1:0];
            lo_d = {lo_q[N-2:0], 1'b1};
         end else begin
            hi_d = div_shift[N-1:0];
            lo_d = {lo_q[N-2:0], 1'b0};
         end
      end else begin
         // Shift-add step: conditionally add multiplicand, shift {carry,hi,lo} right.
         hi_d = mul_sum[N:1];
         lo_d = {mul_sum[0], lo_q[N-1:1]};
      end
   end

   assign done_o = active_q && (cnt_q == SHW'(N - 1));
   assign res_o  = ((op_q == OP_MULHU) || (op_q == OP_REMU)) ? hi_d : lo_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hi_q     <= '0;
         lo_q     <= '0;
         opnd_q   <= '0;
         op_q     <= OP_ADD;
         active_q <= 1'b0;
         cnt_q    <= '0;
      end else if (start_i) begin
         op_q     <= op_i;
         hi_q     <= '0;
         active_q <= 1'b1;
         cnt_q    <= '0;
         if ((op_i == OP_DIVU) || (op_i == OP_REMU)) begin
            opnd_q <= b_i;
            lo_q   <= a_i;
         end else begin
            opnd_q <= a_i;
            lo_q   <= b_i;
         end
      end else if (active_q) begin
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         cnt_q <= cnt_q + 1'b1;
         if (done_o) active_q <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// alu_seq
// Sequential ALU: single-cycle logic/arithmetic/shift/compare ops complete
// one cycle after transfer; mul/mulhu/divu/remu iterate N cycles in
// alu_seq_muldiv and complete N+1 cycles after transfer. The result is held
// until consumed, then the block returns to IDLE.
// Ports:
//   clk, rst_n - clock, synchronous active-low reset
//   bus        - alu_seq_if slave modport (operation in, result out, busy)
//   state_o    - current FSM state, for observation only
// N must match the N of the connected alu_seq_if instance.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int N   = 32,
   parameter int SHW = $clog2(N)
) (
   input  logic   clk,
   input  logic   rst_n,
   alu_seq_if.slave bus,
   output state_e state_o
);

   state_e       state_q;
   logic [N-1:0] result_q;
   logic         zero_q;
   logic         out_valid_q;
   logic         busy_q;

   op_e            op_in;
   logic [SHW-1:0] shamt;
   logic [N-1:0]   alu_res;
   logic           accept;
   logic           md_start;
   logic           md_done;
   logic [N-1:0]   md_res;

   assign op_in    = op_e'(bus.op);
   assign shamt    = bus.b[SHW-1:0];
   assign accept   = (state_q == ST_IDLE) && bus.in_valid;
   assign md_start = accept && is_multi_op(op_in);

   always_comb begin
      alu_res = bus.a;
      case (op_in)
         OP_ADD:  alu_res = bus.a + bus.b;
         OP_SUB:  alu_res = bus.a - bus.b;
         OP_XOR:  alu_res = bus.a ^ bus.b;
         OP_OR:   alu_res = bus.a | bus.b;
         OP_AND:  alu_res = bus.a & bus.b;
         OP_SLL:  alu_res = bus.a << shamt;
         OP_SRL:  alu_res = bus.a >> shamt;
         OP_SLT:  alu_res = {{(N-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
         OP_SRA:  alu_res = $unsigned($signed(bus.a) >>> shamt);
         OP_SLTU: alu_res = {{(N-1){1'b0}}, (bus.a < bus.b)};
         default: alu_res = bus.a;
      endcase
   end

   alu_seq_muldiv #(.N(N), .SHW(SHW)) u_muldiv (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (md_start),
      .op_i    (op_in),
      .a_i     (bus.a),
      .b_i     (bus.b),
      .done_o  (md_done),
      .res_o   (md_res)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         result_q    <= '0;
         zero_q      <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  if (is_multi_op(op_in)) begin
                     state_q <= ST_ITER;
                     busy_q  <= 1'b1;
                  end else begin
                     state_q     <= ST_DONE;
                     result_q    <= alu_res;
                     zero_q      <= (alu_res == '0);
                     out_valid_q <= 1'b1;
                  end
               end
            end
            ST_ITER: begin
               if (md_done) begin
                  state_q     <= ST_DONE;
                  busy_q      <= 1'b0;
                  result_q    <= md_res;
                  zero_q      <= (md_res == '0);
                  out_valid_q <= 1'b1;
               end
            end
            ST_DONE: begin
               // Returning to IDLE (not accepting) on the consume edge sets
               // the two-cycle minimum issue interval.
               if (bus.out_ready) begin
                  state_q     <= ST_IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.zero      = zero_q;
   assign bus.busy      = busy_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
   import alu_seq_pkg::*;

   localparam int W       = 32;
   localparam int TIMEOUT = 100;

   logic   clk;
   logic   rst_n;
   state_e state_dbg;

   int compared;
   int mismatched;

   logic [W-1:0] exp_q[$];

   alu_seq_if #(.N(W)) bus ();

   alu_seq #(.N(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus.slave),
      .state_o (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [W-1:0] ref_alu(input logic [3:0] op_v, input logic [W-1:0] a_v, input logic [W-1:0] b_v);
      logic [63:0] prod;
      int          sh;
      sh   = int'(b_v[4:0]);
      prod = {32'd0, a_v} * {32'd0, b_v};
      case (op_v)
         4'h0: return a_v + b_v;
         4'h1: return a_v - b_v;
         4'h2: return a_v ^ b_v;
         4'h3: return a_v | b_v;
         4'h4: return a_v & b_v;
         4'h5: return a_v << sh;
         4'h6: return a_v >> sh;
         4'h7: return ($signed(a_v) < $signed(b_v)) ? 32'd1 : 32'd0;
         4'h8: return $unsigned($signed(a_v) >>> sh);
         4'h9: return (a_v < b_v) ? 32'd1 : 32'd0;
         4'hA: return prod[31:0];
         4'hB: return prod[63:32];
         4'hC: return (b_v == 0) ? 32'hFFFF_FFFF : a_v / b_v;
         4'hD: return (b_v == 0) ? a_v : a_v % b_v;
         default: return a_v;
      endcase
   endfunction

   function automatic int ref_latency(input logic [3:0] op_v);
      return (op_v >= 4'hA && op_v <= 4'hD) ? W + 1 : 1;
   endfunction

   // ---------------- driver tasks ----------------
   // Issue one operation, keep in_valid high with junk operands while the
   // operation is in flight, and wait (bounded) for out_valid.
   task automatic issue(input logic [3:0] op_v, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                        output logic [W-1:0] res_v, output logic zero_v,
                        output int lat_v, output int busy_v, output logic ready_v);
      @(negedge clk);
      ready_v      = bus.in_ready;
      bus.in_valid = 1'b1;
      bus.op       = op_v;
      bus.a        = a_v;
      bus.b        = b_v;
      @(posedge clk);
      #1;
      bus.a  = $urandom;
      bus.b  = $urandom;
      bus.op = 4'($urandom_range(0, 15));
      lat_v  = 1;
      busy_v = 0;
      while (bus.out_valid !== 1'b1 && lat_v < TIMEOUT) begin
         if (bus.busy === 1'b1) busy_v++;
         @(posedge clk);
         #1;
         lat_v++;
      end
      if (bus.out_valid !== 1'b1) lat_v = -1;
      bus.in_valid = 1'b0;
      res_v  = bus.result;
      zero_v = bus.zero;
   endtask

   // Hold out_ready low for 'hold' cycles, counting cycles where the held
   // result is disturbed, then consume it.
   task automatic consume(input int hold, input logic [W-1:0] held, output int bad,
                          output logic ov_after, output logic ir_after);
      bad = 0;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid !== 1'b1 || bus.result !== held || bus.in_ready !== 1'b0) bad++;
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      ov_after = bus.out_valid;
      ir_after = bus.in_ready;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      compared++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.result !== '0 || bus.zero !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_outputs: got ov=%b busy=%b res=%h zero=%b, need 0 0 0 0",
                  bus.out_valid, bus.busy, bus.result, bus.zero);
      end
      compared++;
      if (state_dbg !== ST_IDLE) begin
         mismatched++;
         $display("FAIL reset_state: got %0d need %0d", state_dbg, ST_IDLE);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      compared++;
      if (bus.in_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL ready_after_reset: got %b need 1", bus.in_ready);
      end
   endtask

   task automatic test_directed();
      logic [3:0]   ops [7] = '{4'h0, 4'h1, 4'h7, 4'h9, 4'h8, 4'h6, 4'hB};
      logic [W-1:0] as  [7] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
      logic [W-1:0] bs  [7] = '{32'd1, 32'd5, 32'd1, 32'd1, 32'h24, 32'h24, 32'hFFFF_FFFF};
      logic [W-1:0] exp [7] = '{32'd0, 32'd0, 32'd1, 32'd0, 32'hF800_0000, 32'h0800_0000, 32'hFFFF_FFFE};
      int           lats[7] = '{1, 1, 1, 1, 1, 1, W + 1};
      int           bcs [7] = '{0, 0, 0, 0, 0, 0, W};
      logic [W-1:0] res;
      logic         z, rdy, ov, ir;
      int           lat, bc, bad;
      for (int i = 0; i < 7; i++) begin
         issue(ops[i], as[i], bs[i], res, z, lat, bc, rdy);
         compared++;
         if (res !== exp[i] || z !== (exp[i] == 0)) begin
            mismatched++;
            $display("FAIL directed_%0d_result: got %h/z%b need %h/z%b", i, res, z, exp[i], exp[i] == 0);
         end
         compared++;
         if (lat !== lats[i] || bc !== bcs[i]) begin
            mismatched++;
            $display("FAIL directed_%0d_timing: got lat=%0d busy=%0d need lat=%0d busy=%0d", i, lat, bc, lats[i], bcs[i]);
         end
         consume(0, res, bad, ov, ir);
      end
   endtask

   task automatic test_div_by_zero();
      logic [3:0]   ops [2] = '{4'hC, 4'hD};
      logic [W-1:0] exp [2] = '{32'hFFFF_FFFF, 32'd7};
      logic [W-1:0] res;
      logic         z, rdy, ov, ir;
      int           lat, bc, bad;
      for (int i = 0; i < 2; i++) begin
         issue(ops[i], 32'd7, 32'd0, res, z, lat, bc, rdy);
         compared++;
         if (res !== exp[i] || lat !== W + 1) begin
            mismatched++;
            $display("FAIL divzero_%0d: got %h lat=%0d need %h lat=%0d", i, res, lat, exp[i], W + 1);
         end
         consume(5, exp[i], bad, ov, ir);
         compared++;
         if (bad !== 0) begin
            mismatched++;
            $display("FAIL divzero_%0d_hold: got %0d disturbed cycles need 0", i, bad);
         end
         compared++;
         if (ov !== 1'b0 || ir !== 1'b1) begin
            mismatched++;
            $display("FAIL divzero_%0d_release: got ov=%b ir=%b need 0 1", i, ov, ir);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] res;
      logic         z, rdy, ov, ir;
      int           lat, bc, bad;
      issue(4'h0, 32'd1, 32'd2, res, z, lat, bc, rdy);
      // Offer the next op on the consume edge: it must not transfer there.
      bus.in_valid  = 1'b1;
      bus.op        = 4'h2;
      bus.a         = 32'hF0F0_1234;
      bus.b         = 32'h0FF0_1234;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      compared++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL b2b_consume_edge: got ov=%b ir=%b need 0 1", bus.out_valid, bus.in_ready);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      compared++;
      if (bus.out_valid !== 1'b1 || bus.result !== 32'hFF00_0000) begin
         mismatched++;
         $display("FAIL b2b_second: got ov=%b res=%h need 1 ff000000", bus.out_valid, bus.result);
      end
      consume(0, bus.result, bad, ov, ir);
   endtask

   task automatic test_reset_mid_iter();
      logic [W-1:0] res;
      logic         z, rdy, ov, ir;
      int           lat, bc, bad, seen;
      issue(4'h0, 32'd3, 32'd4, res, z, lat, bc, rdy);
      consume(0, res, bad, ov, ir);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.op       = 4'hC;
      bus.a        = 32'd100;
      bus.b        = 32'd7;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      compared++;
      if (bus.busy !== 1'b1) begin
         mismatched++;
         $display("FAIL midreset_busy_before: got %b need 1", bus.busy);
      end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      compared++;
      if (state_dbg !== ST_IDLE || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.result !== '0) begin
         mismatched++;
         $display("FAIL midreset_after: got st=%0d busy=%b ov=%b res=%h need 0 0 0 0",
                  state_dbg, bus.busy, bus.out_valid, bus.result);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (W + 8) begin
         @(posedge clk);
         #1;
         if (bus.out_valid === 1'b1) seen++;
      end
      compared++;
      if (seen !== 0) begin
         mismatched++;
         $display("FAIL midreset_no_result: got %0d valid cycles need 0", seen);
      end
      issue(4'h0, 32'd10, 32'd20, res, z, lat, bc, rdy);
      compared++;
      if (res !== 32'd30 || lat !== 1 || rdy !== 1'b1) begin
         mismatched++;
         $display("FAIL midreset_next_add: got %h lat=%0d rdy=%b need 0000001e 1 1", res, lat, rdy);
      end
      consume(0, res, bad, ov, ir);
   endtask

   task automatic test_random();
      logic [3:0]   op_v;
      logic [W-1:0] a_v, b_v, res, exp;
      logic         z, rdy, ov, ir;
      int           lat, bc, bad;
      for (int i = 0; i < 40; i++) begin
         op_v = 4'($urandom_range(0, 15));
         a_v  = $urandom;
         case ($urandom_range(0, 3))
            0:       b_v = 32'd0;
            1:       b_v = 32'($urandom_range(1, 300));
            2:       b_v = a_v;
            default: b_v = $urandom;
         endcase
         exp_q.push_back(ref_alu(op_v, a_v, b_v));
         issue(op_v, a_v, b_v, res, z, lat, bc, rdy);
         exp = exp_q.pop_front();
         compared++;
         if (res !== exp || z !== (exp == 0)) begin
            mismatched++;
            $display("FAIL rand_%0d op=%h a=%h b=%h: got %h/z%b need %h/z%b", i, op_v, a_v, b_v, res, z, exp, exp == 0);
         end
         compared++;
         if (lat !== ref_latency(op_v) || rdy !== 1'b1) begin
            mismatched++;
            $display("FAIL rand_%0d_timing op=%h: got lat=%0d rdy=%b need lat=%0d rdy=1", i, op_v, lat, rdy, ref_latency(op_v));
         end
         consume($urandom_range(0, 2), res, bad, ov, ir);
         compared++;
         if (bad !== 0 || ov !== 1'b0 || ir !== 1'b1) begin
            mismatched++;
            $display("FAIL rand_%0d_handshake: got bad=%0d ov=%b ir=%b need 0 0 1", i, bad, ov, ir);
         end
      end
   endtask

   // ---------------- main sequence and report ----------------
   initial begin
      compared      = 0;
      mismatched    = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.op        = '0;
      test_reset();
      test_directed();
      test_div_by_zero();
      test_back_to_back();
      test_reset_mid_iter();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
